// File: rtl/sprite_fetch_sched.sv
// sprite_fetch_sched: shares one sprite row ROM among NUM_OBJ objects, fetching rows into shadow regs per line
// Ports: clk, rst_n (async active-low); line_start/next_y begin a fetch; obj_y/obj_dir/obj_base per-slot
//   object state; line_swap copies shadow -> row_active/row_valid; rom_en/rom_addr/rom_data shared ROM
//   (1-cycle read latency); busy, done, overrun status.
module sprite_fetch_sched #(
   parameter int NUM_OBJ  = 5,
   parameter int SPRITE_H = 16,
   parameter int ROW_W    = 64,
   parameter int ROM_AW   = 9
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       line_start,
   input  logic [9:0]                 next_y,
   input  logic [NUM_OBJ*10-1:0]      obj_y,
   input  logic [NUM_OBJ*4-1:0]       obj_dir,
   input  logic [NUM_OBJ*ROM_AW-1:0]  obj_base,
   input  logic                       line_swap,
   output logic                       rom_en,
   output logic [ROM_AW-1:0]          rom_addr,
   input  logic [ROW_W-1:0]           rom_data,
   output logic [NUM_OBJ*ROW_W-1:0]   row_active,
   output logic [NUM_OBJ-1:0]         row_valid,
   output logic                       busy,
   output logic                       done,
   output logic                       overrun
);
   localparam int IW = $clog2(NUM_OBJ);
   localparam int HW = $clog2(SPRITE_H);
   localparam logic [1:0] S_IDLE = 2'd0, S_ISSUE = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3;
   logic [1:0]                 state;
   logic [IW-1:0]              idx;
   logic [9:0]                 snap_ny;
   logic [NUM_OBJ*10-1:0]      snap_y;
   logic [NUM_OBJ*4-1:0]       snap_dir;
   logic [NUM_OBJ*ROM_AW-1:0]  snap_base;
   logic [NUM_OBJ*ROW_W-1:0]   shadow;
   logic [NUM_OBJ-1:0]         shadow_valid;
   logic                       p1_v, p1_hit, p2_v, p2_hit;
   logic [IW-1:0]              p1_idx, p2_idx;
   logic [9:0]                 cur_y, dy;
   logic [3:0]                 cur_dir;
   logic [ROM_AW-1:0]          cur_base, cur_addr;
   logic                       hit, issue, restart;
   assign busy = state != S_IDLE;
   always_comb begin
      cur_y    = snap_y[idx*10 +: 10];
      cur_dir  = snap_dir[idx*4 +: 4];
      cur_base = snap_base[idx*ROM_AW +: ROM_AW];
      dy       = snap_ny - cur_y;
      hit      = (snap_ny >= cur_y) && (dy < 10'(SPRITE_H));
      cur_addr = cur_base + (ROM_AW'(cur_dir) << HW) + ROM_AW'(dy[HW-1:0]);
      // the edge that accepts a new line_start issues nothing for the abandoned slot
      issue    = (state == S_ISSUE) && !line_start;
      // DONE is already finished, so a line_start there is a normal start, not an overrun
      restart  = line_start && (state == S_ISSUE || state == S_DRAIN);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         idx <= '0;
         snap_ny <= '0;
         snap_y <= '0;
         snap_dir <= '0;
         snap_base <= '0;
         shadow <= '0;
         shadow_valid <= '0;
         p1_v <= 1'b0;
         p1_hit <= 1'b0;
         p1_idx <= '0;
         p2_v <= 1'b0;
         p2_hit <= 1'b0;
         p2_idx <= '0;
         rom_en <= 1'b0;
         rom_addr <= '0;
         row_active <= '0;
         row_valid <= '0;
         done <= 1'b0;
         overrun <= 1'b0;
      end else begin
         done <= state == S_DONE;
         overrun <= restart || (line_swap && busy);
         rom_en <= issue && hit;
         if (issue && hit) rom_addr <= cur_addr;
         // read pipe runs independently of the FSM so in-flight rows still land after an abort
         p1_v <= issue;
         p1_hit <= hit;
         p1_idx <= idx;
         p2_v <= p1_v;
         p2_hit <= p1_hit;
         p2_idx <= p1_idx;
         if (p2_v) begin
            shadow[p2_idx*ROW_W +: ROW_W] <= p2_hit ? rom_data : '0;
            shadow_valid[p2_idx] <= p2_hit;
         end
         if (line_swap && busy) row_valid <= '0;
         else if (line_swap) begin
            row_active <= shadow;
            row_valid <= shadow_valid;
         end
         if (line_start) begin
            state <= S_ISSUE;
            idx <= '0;
            snap_ny <= next_y;
            snap_y <= obj_y;
            snap_dir <= obj_dir;
            snap_base <= obj_base;
         end else if (state == S_ISSUE) begin
            state <= (idx == IW'(NUM_OBJ - 1)) ? S_DRAIN : S_ISSUE;
            idx <= (idx == IW'(NUM_OBJ - 1)) ? '0 : idx + 1'b1;
         end else if (state == S_DRAIN) begin
            state <= (idx == IW'(1)) ? S_DONE : S_DRAIN;
            idx <= idx + 1'b1;
         end else if (state == S_DONE) state <= S_IDLE;
      end
   end
endmodule

// File: tb/tb_sprite_fetch_sched.sv
// tb_sprite_fetch_sched: table vectors, directed corner sequences and randomized fetches vs a line-level model
module tb_sprite_fetch_sched;
   logic clk = 1'b0, rst_n = 1'b0, line_start = 1'b0, line_swap = 1'b0;
   logic [9:0] ny = '0;
   logic [9:0] oy[5];
   logic [3:0] dr[5];
   logic [8:0] bs[5];
   logic [49:0] obj_y;
   logic [19:0] obj_dir;
   logic [44:0] obj_base;
   logic rom_en, busy, done, overrun;
   logic [8:0] rom_addr;
   logic [63:0] rom_data = '0;
   logic [319:0] row_active;
   logic [4:0] row_valid;
   int total = 0, bad = 0;
   bit e_hit[5];
   logic [8:0] e_addr[5];
   bit e_valid[5], p_valid[5];
   logic [63:0] e_row[5], p_row[5], a_row[5];

   sprite_fetch_sched dut (
      .clk(clk), .rst_n(rst_n), .line_start(line_start), .next_y(ny),
      .obj_y(obj_y), .obj_dir(obj_dir), .obj_base(obj_base), .line_swap(line_swap),
      .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
      .row_active(row_active), .row_valid(row_valid),
      .busy(busy), .done(done), .overrun(overrun)
   );

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < 5; i++) begin
         obj_y[i*10 +: 10] = oy[i];
         obj_dir[i*4 +: 4] = dr[i];
         obj_base[i*9 +: 9] = bs[i];
      end
   end

   function automatic logic [63:0] rom_fn(input logic [8:0] a);
      return {16'hDEAD, 16'(a), ~16'(a), 16'(a) * 16'd5 + 16'h1234};
   endfunction

   // ROM with one cycle of read latency
   always @(posedge clk) if (rom_en) rom_data <= rom_fn(rom_addr);

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // line-level model: which slots cover the line and where their row lives
   task automatic compute_expect;
      for (int i = 0; i < 5; i++) begin
         int n = int'(ny), o = int'(oy[i]);
         e_hit[i] = (n >= o) && (n - o < 16);
         e_addr[i] = 9'((int'(bs[i]) + int'(dr[i]) * 16 + (n - o)) % 512);
         e_valid[i] = e_hit[i];
         e_row[i] = e_hit[i] ? rom_fn(e_addr[i]) : 64'd0;
      end
   endtask

   task automatic rnd;
      ny = 10'($urandom_range(0, 1023));
      for (int i = 0; i < 5; i++) begin
         oy[i] = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'(ny - 10'($urandom_range(0, 20)));
         dr[i] = 4'($urandom);
         bs[i] = 9'($urandom);
      end
   endtask

   task automatic launch(input bit sw, input bit ed, input bit eo);
      p_valid = e_valid;
      p_row = e_row;
      compute_expect();
      line_start = 1'b1;
      line_swap = sw;
      tick();
      line_start = 1'b0;
      line_swap = 1'b0;
      chk("busy_start", busy, 1);
      chk("done_start", done, ed);
      chk("ovr_start", overrun, eo);
      if (sw) for (int i = 0; i < 5; i++) begin
         chk("swap_old_valid", row_valid[i], p_valid[i]);
         chk("swap_old_row", row_active[i*64 +: 64], p_row[i]);
         a_row[i] = p_row[i];
      end
   endtask

   task automatic body(input bit scr);
      for (int i = 0; i < 5; i++) begin
         if (scr) rnd();
         tick();
         chk("rom_en", rom_en, e_hit[i]);
         if (e_hit[i]) chk("rom_addr", rom_addr, e_addr[i]);
         chk("done_issue", done, 0);
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("rom_en_drain", rom_en, 0);
         chk("done_drain", done, 0);
         chk("busy_drain", busy, 1);
      end
   endtask

   task automatic finish_fetch;
      tick();
      chk("done_pulse", done, 1);
      chk("busy_fall", busy, 0);
      tick();
      chk("done_clear", done, 0);
   endtask

   task automatic do_swap;
      line_swap = 1'b1;
      tick();
      line_swap = 1'b0;
      chk("swap_ovr", overrun, 0);
      for (int i = 0; i < 5; i++) begin
         chk("row_valid", row_valid[i], e_valid[i]);
         chk("row_active", row_active[i*64 +: 64], e_row[i]);
         a_row[i] = e_row[i];
      end
   endtask

   task automatic all_hit(input logic [9:0] y);
      ny = y;
      for (int i = 0; i < 5; i++) begin
         oy[i] = y - 10'(i * 3);
         dr[i] = 4'(i);
         bs[i] = 9'(i * 40);
      end
   endtask

   typedef struct {
      int ny, oy, base, dir;
      bit en;
      int addr;
   } vec_t;
   vec_t tv[6];

   initial begin
      tv[0] = '{47, 40, 64, 2, 1'b1, 103};
      tv[1] = '{100, 85, 0, 0, 1'b1, 15};
      tv[2] = '{100, 84, 5, 1, 1'b0, 0};
      tv[3] = '{100, 101, 7, 0, 1'b0, 0};
      tv[4] = '{53, 50, 511, 0, 1'b1, 2};
      tv[5] = '{0, 0, 300, 15, 1'b1, 28};
      for (int i = 0; i < 5; i++) begin
         oy[i] = 10'd1023;
         dr[i] = '0;
         bs[i] = '0;
      end
      #3;
      chk("rst_rom_en", rom_en, 0);
      chk("rst_rom_addr", rom_addr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ovr", overrun, 0);
      chk("rst_valid", row_valid, 0);
      chk("rst_row", row_active[63:0], 0);
      tick();
      rst_n = 1'b1;
      tick();

      for (int k = 0; k < 6; k++) begin
         ny = 10'(tv[k].ny);
         oy[0] = 10'(tv[k].oy);
         bs[0] = 9'(tv[k].base);
         dr[0] = 4'(tv[k].dir);
         launch(0, 0, 0);
         tick();
         chk("tbl_en", rom_en, tv[k].en);
         if (tv[k].en) chk("tbl_addr", rom_addr, tv[k].addr);
         repeat (6) tick();
         finish_fetch();
         line_swap = 1'b1;
         tick();
         line_swap = 1'b0;
         chk("tbl_valid", row_valid[0], tv[k].en);
         chk("tbl_row", row_active[63:0], tv[k].en ? rom_fn(9'(tv[k].addr)) : 64'd0);
      end

      ny = 10'd100;
      oy[0] = 10'd100; oy[1] = 10'd90; oy[2] = 10'd85; oy[3] = 10'd115; oy[4] = 10'd300;
      for (int i = 0; i < 5; i++) begin
         dr[i] = 4'(i + 1);
         bs[i] = 9'(i * 100);
      end
      launch(0, 0, 0);
      body(0);
      finish_fetch();
      do_swap();
      do_swap();

      all_hit(10'd400);
      launch(0, 0, 0);
      body(0);
      finish_fetch();
      rnd();
      launch(1, 0, 0);
      body(1);
      finish_fetch();
      do_swap();

      rnd();
      launch(0, 0, 0);
      body(0);
      all_hit(10'd620);
      launch(0, 1, 0);
      body(0);
      finish_fetch();
      do_swap();

      all_hit(10'd200);
      launch(0, 0, 0);
      tick();
      line_swap = 1'b1;
      tick();
      line_swap = 1'b0;
      chk("busy_swap_ovr", overrun, 1);
      chk("busy_swap_valid", row_valid, 0);
      for (int i = 0; i < 5; i++) chk("busy_swap_row", row_active[i*64 +: 64], a_row[i]);
      rnd();
      launch(0, 0, 1);
      body(0);
      finish_fetch();
      do_swap();

      all_hit(10'd777);
      launch(0, 0, 0);
      repeat (3) tick();
      #2 rst_n = 1'b0;
      #1;
      chk("arst_rom_en", rom_en, 0);
      chk("arst_rom_addr", rom_addr, 0);
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_valid", row_valid, 0);
      chk("arst_row", row_active[63:0], 0);
      repeat (2) tick();
      #2 rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("post_rst_done", done, 0);
         chk("post_rst_busy", busy, 0);
      end
      rnd();
      launch(0, 0, 0);
      body(0);
      finish_fetch();
      do_swap();

      for (int r = 0; r < 20; r++) begin
         rnd();
         launch(0, 0, 0);
         body(1);
         finish_fetch();
         do_swap();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
